// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves conditional branches, drives the PC redirect
// and squashes FLUSH_DEPTH wrong-path instructions after a taken branch.
module ex_mem_stage #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic            ex_zero,
  input  logic            ex_blt,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [XLEN-1:0] ex_branch_target,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_mem_to_reg,
  input  logic [1:0]      ex_branch_type,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_alu_result,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic            mem_mem_to_reg,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target,
  output logic            flush_out
);

  localparam int unsigned CW = $clog2(FLUSH_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH = CW'(FLUSH_DEPTH);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic {IDLE, SQUASH} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          taken;

  always_comb begin
    taken = 1'b0;
    unique case (ex_branch_type)
      2'b01:   taken = ex_zero;
      2'b10:   taken = ~ex_zero;
      2'b11:   taken = ex_blt;
      default: taken = 1'b0;
    endcase
    taken = taken & ex_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      mem_valid      <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      mem_reg_write  <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      pc_src         <= 1'b0;
      branch_target  <= '0;
      flush_out      <= 1'b0;
    end else if (!stall) begin
      if (flush || state == SQUASH) begin
        mem_valid      <= 1'b0;
        mem_alu_result <= '0;
        mem_store_data <= '0;
        mem_rd         <= '0;
        mem_reg_write  <= 1'b0;
        mem_mem_read   <= 1'b0;
        mem_mem_write  <= 1'b0;
        mem_mem_to_reg <= 1'b0;
        pc_src         <= 1'b0;
        branch_target  <= '0;
        // External flush keeps the FSM state but still consumes squash slots,
        // stopping at 1 so the final slot retires the squash on a normal edge.
        if (flush) begin
          if (state == SQUASH && count > ONE) count <= count - ONE;
        end else if (count == ONE) begin
          state     <= IDLE;
          count     <= '0;
          flush_out <= 1'b0;
        end else begin
          count <= count - ONE;
        end
      end else begin
        mem_valid      <= ex_valid;
        mem_alu_result <= ex_alu_result;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
        mem_reg_write  <= ex_reg_write  & ex_valid;
        mem_mem_read   <= ex_mem_read   & ex_valid;
        mem_mem_write  <= ex_mem_write  & ex_valid;
        mem_mem_to_reg <= ex_mem_to_reg & ex_valid;
        pc_src         <= taken;
        branch_target  <= ex_branch_target;
        if (taken) begin
          state     <= SQUASH;
          count     <= DEPTH;
          flush_out <= 1'b1;
        end
      end
    end
  end

endmodule
